// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes and pipeline flush.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic [2*XLEN-1:0]     prod_q, prod_d;
    logic [CW-1:0]         count_q, count_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic                  rs1_signed, rs2_signed;
    logic                  s1_in, s2_in;
    logic [XLEN-1:0]       mag1, mag2;
    logic                  is_div_in;
    logic                  div_by_zero, div_overflow;

    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [XLEN:0]         div_shift, div_diff;
    logic [2*XLEN-1:0]     div_next;
    logic [2*XLEN-1:0]     step_next;
    logic [2*XLEN-1:0]     mul_full;
    logic [XLEN-1:0]       mul_res, div_res, quot, rem;

    // Operand signedness and magnitudes for the incoming request
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        case (op)
            3'b001, 3'b100, 3'b110: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            3'b010:  rs1_signed = 1'b1;
            default: ;
        endcase
        s1_in        = rs1_signed & rs1[XLEN-1];
        s2_in        = rs2_signed & rs2[XLEN-1];
        mag1         = s1_in ? -rs1 : rs1;
        mag2         = s2_in ? -rs2 : rs2;
        is_div_in    = op[2];
        div_by_zero  = is_div_in && (rs2 == '0);
        div_overflow = rs1_signed && is_div_in
                       && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    end

    // One iteration step; the divider keeps {remainder, quotient} in prod_q
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[XLEN])
            div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        step_next = op_q[2] ? div_next : mul_next;

        mul_full = (s1_q ^ s2_q) ? -step_next : step_next;
        mul_res  = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        quot     = step_next[XLEN-1:0];
        rem      = step_next[2*XLEN-1:XLEN];
        if (op_q[1])
            div_res = s1_q ? -rem : rem;
        else
            div_res = (s1_q ^ s2_q) ? -quot : quot;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    s1_d    = s1_in;
                    s2_d    = s2_in;
                    count_d = '0;
                    // Divide corner cases bypass iteration entirely
                    if (div_by_zero) begin
                        result_d = op[1] ? rs1 : '1;
                        state_d  = DONE;
                    end else if (div_overflow) begin
                        result_d = op[1] ? '0 : rs1;
                        state_d  = DONE;
                    end else begin
                        opb_d   = is_div_in ? mag2 : mag1;
                        prod_d  = {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prod_d  = step_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(XLEN-1)) begin
                    result_d = op_q[2] ? div_res : mul_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over accept and over a pending result handoff
        if (flush) begin
            state_d  = IDLE;
            op_d     = op_q;
            s1_d     = s1_q;
            s2_d     = s2_q;
            opb_d    = opb_q;
            prod_d   = prod_q;
            count_d  = count_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            opb_q    <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule
